regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter_pkg.sv | 16 +
 rtl/regfile_wb_arbiter_if.sv | 43 ++++
 rtl/regfile_wb_arbiter_wb_slot.sv | 47 ++++
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared widths, source encoding and writeback request type
package regfile_wb_arbiter_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_AW   = 5;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  typedef struct packed {
    logic                valid;
    logic [DEF_AW-1:0]   rd;
    logic [DEF_XLEN-1:0] wd;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request and regfile write bundle (REGFILE_WB_PENDCHK_EN adds chk_rs/chk_pend)
interface regfile_wb_arbiter_if #(
  parameter int XLEN = regfile_wb_arbiter_pkg::DEF_XLEN,
  parameter int AW   = regfile_wb_arbiter_pkg::DEF_AW
);

  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_wd;
  logic            mem_valid;
  logic            mem_ready;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_wd;
  logic            rf_we;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic            rf_src;

`ifdef REGFILE_WB_PENDCHK_EN
  logic [AW-1:0]   chk_rs;
  logic            chk_pend;

  modport master (
    output alu_valid, alu_rd, alu_wd, mem_valid, mem_rd, mem_wd, chk_rs,
    input  alu_ready, mem_ready, rf_we, rf_rd, rf_wd, rf_src, chk_pend
  );
  modport slave (
    input  alu_valid, alu_rd, alu_wd, mem_valid, mem_rd, mem_wd, chk_rs,
    output alu_ready, mem_ready, rf_we, rf_rd, rf_wd, rf_src, chk_pend
  );
`else
  modport master (
    output alu_valid, alu_rd, alu_wd, mem_valid, mem_rd, mem_wd,
    input  alu_ready, mem_ready, rf_we, rf_rd, rf_wd, rf_src
  );
  modport slave (
    input  alu_valid, alu_rd, alu_wd, mem_valid, mem_rd, mem_wd,
    output alu_ready, mem_ready, rf_we, rf_rd, rf_wd, rf_src
  );
`endif

endinterface

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// rtl/regfile_wb_arbiter_wb_slot.sv - one-entry writeback holding buffer with x0 filter
module wb_slot
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int AW   = DEF_AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [AW-1:0]   i_rd,
  input  logic [XLEN-1:0] i_wd,
  input  logic            i_grant,
  output logic            o_v,
  output logic [AW-1:0]   o_rd,
  output logic [XLEN-1:0] o_wd
);

  logic            r_v;
  logic [AW-1:0]   r_rd;
  logic [XLEN-1:0] r_wd;
  logic            w_ready;

  // Ready looks only at local state and the grant, never at i_valid.
  assign w_ready = !r_v || i_grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v  <= 1'b0;
      r_rd <= '0;
      r_wd <= '0;
    end else if (i_valid && w_ready) begin
      r_v  <= (i_rd != '0);
      r_rd <= i_rd;
      r_wd <= i_wd;
    end else if (i_grant) begin
      r_v <= 1'b0;
    end
  end

  assign o_ready = w_ready;
  assign o_v     = r_v;
  assign o_rd    = r_rd;
  assign o_wd    = r_wd;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - arbitrates ALU/load writebacks onto one registered regfile write port
// REGFILE_WB_PENDCHK_EN adds the chk_rs/chk_pend in-flight destination lookup.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int AW         = DEF_AW,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  wb
);

  logic            w_alu_v;
  logic [AW-1:0]   w_alu_rd;
  logic [XLEN-1:0] w_alu_wd;
  logic            w_mem_v;
  logic [AW-1:0]   w_mem_rd;
  logic [XLEN-1:0] w_mem_wd;
  logic            w_gnt_alu;
  logic            w_gnt_mem;
  logic            w_force_alu;

  logic            r_we;
  logic [AW-1:0]   r_rd;
  logic [XLEN-1:0] r_wd;
  logic            r_src;
  logic [3:0]      r_starve;

  wb_slot #(.XLEN(XLEN), .AW(AW)) u_alu_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (wb.alu_valid),
    .o_ready (wb.alu_ready),
    .i_rd    (wb.alu_rd),
    .i_wd    (wb.alu_wd),
    .i_grant (w_gnt_alu),
    .o_v     (w_alu_v),
    .o_rd    (w_alu_rd),
    .o_wd    (w_alu_wd)
  );

  wb_slot #(.XLEN(XLEN), .AW(AW)) u_mem_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (wb.mem_valid),
    .o_ready (wb.mem_ready),
    .i_rd    (wb.mem_rd),
    .i_wd    (wb.mem_wd),
    .i_grant (w_gnt_mem),
    .o_v     (w_mem_v),
    .o_rd    (w_mem_rd),
    .o_wd    (w_mem_wd)
  );

  // Loads normally win; a starved ALU entry takes the port once it has lost STARVE_MAX times.
  assign w_force_alu = (r_starve == 4'(STARVE_MAX));
  assign w_gnt_mem   = w_mem_v && !(w_alu_v && w_force_alu);
  assign w_gnt_alu   = w_alu_v && !w_gnt_mem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_rd     <= '0;
      r_wd     <= '0;
      r_src    <= SRC_ALU;
      r_starve <= '0;
    end else begin
      r_we <= w_gnt_alu || w_gnt_mem;
      if (w_gnt_mem) begin
        r_rd  <= w_mem_rd;
        r_wd  <= w_mem_wd;
        r_src <= SRC_MEM;
      end else if (w_gnt_alu) begin
        r_rd  <= w_alu_rd;
        r_wd  <= w_alu_wd;
        r_src <= SRC_ALU;
      end
      if (w_alu_v && w_gnt_mem) begin
        if (!w_force_alu) r_starve <= r_starve + 4'd1;
      end else begin
        r_starve <= '0;
      end
    end
  end

  assign wb.rf_we  = r_we;
  assign wb.rf_rd  = r_rd;
  assign wb.rf_wd  = r_wd;
  assign wb.rf_src = r_src;

`ifdef REGFILE_WB_PENDCHK_EN
  assign wb.chk_pend = (wb.chk_rs != '0) &&
                       ((w_alu_v && (w_alu_rd == wb.chk_rs)) ||
                        (w_mem_v && (w_mem_rd == wb.chk_rs)) ||
                        (r_we    && (r_rd     == wb.chk_rs)));
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized and directed checks against a behavioural writeback model
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int SM = 3;
  localparam int AW = DEF_AW;
  localparam int XL = DEF_XLEN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(XL), .AW(AW)) bus ();

  regfile_wb_arbiter #(.XLEN(XL), .AW(AW), .STARVE_MAX(SM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: pending entry per source (0=ALU, 1=MEM), consecutive ALU losses, last issued write.
  wb_req_t        m_buf [2];
  int             m_loss;
  logic           m_we;
  logic [AW-1:0]  m_ord;
  logic [XL-1:0]  m_owd;
  logic           m_src;

  logic           in_av, in_mv;
  logic [AW-1:0]  in_ard, in_mrd, chk_rs_in;
  logic [XL-1:0]  in_awd, in_mwd;
  bit             acc_a, acc_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_grant();
    if (m_buf[0].valid && m_buf[1].valid) return (m_loss == SM) ? 0 : 1;
    if (m_buf[1].valid) return 1;
    if (m_buf[0].valid) return 0;
    return -1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) m_buf[s] = '0;
    m_loss = 0;
    m_we   = 1'b0;
    m_ord  = '0;
    m_owd  = '0;
    m_src  = 1'b0;
  endtask

  task automatic compare();
    int   g;
    logic pend;
    g = m_grant();
    check("alu_ready", bus.alu_ready, !m_buf[0].valid || g == 0);
    check("mem_ready", bus.mem_ready, !m_buf[1].valid || g == 1);
    check("rf_we",  bus.rf_we,  m_we);
    check("rf_rd",  bus.rf_rd,  m_ord);
    check("rf_wd",  bus.rf_wd,  m_owd);
    check("rf_src", bus.rf_src, m_src);
    pend = (chk_rs_in != 0) && ((m_buf[0].valid && m_buf[0].rd == chk_rs_in) ||
                                (m_buf[1].valid && m_buf[1].rd == chk_rs_in) ||
                                (m_we && m_ord == chk_rs_in));
`ifdef REGFILE_WB_PENDCHK_EN
    check("chk_pend", bus.chk_pend, pend);
`else
    if (pend && 1'b0) $display("unused");
`endif
  endtask

  // Drive one cycle of inputs (at negedge), advance the model across the coming edge, then check.
  task automatic step(input bit rst);
    int g;
    bit ra, rm;
    rst_n = rst;
    bus.alu_valid = in_av; bus.alu_rd = in_ard; bus.alu_wd = in_awd;
    bus.mem_valid = in_mv; bus.mem_rd = in_mrd; bus.mem_wd = in_mwd;
`ifdef REGFILE_WB_PENDCHK_EN
    bus.chk_rs = chk_rs_in;
`endif
    g  = m_grant();
    ra = !m_buf[0].valid || g == 0;
    rm = !m_buf[1].valid || g == 1;
    acc_a = rst && in_av && ra;
    acc_m = rst && in_mv && rm;
    if (!rst) begin
      model_reset();
    end else begin
      m_loss = (m_buf[0].valid && g == 1) ? ((m_loss < SM) ? m_loss + 1 : SM) : 0;
      m_we = (g >= 0);
      if (g >= 0) begin
        m_ord = m_buf[g].rd;
        m_owd = m_buf[g].wd;
        m_src = g[0];
        m_buf[g].valid = 1'b0;
      end
      if (acc_a) m_buf[0] = '{valid: in_ard != 0, rd: in_ard, wd: in_awd};
      if (acc_m) m_buf[1] = '{valid: in_mrd != 0, rd: in_mrd, wd: in_mwd};
    end
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    in_av = 1'b0;
    in_mv = 1'b0;
    repeat (n) step(1'b1);
  endtask

  initial begin
    int ai, mi, nw, ng;
    bit got;
    model_reset();
    in_av = 1'b1; in_ard = 5'd3; in_awd = 32'h1111_2222;
    in_mv = 1'b1; in_mrd = 5'd4; in_mwd = 32'h3333_4444;
    chk_rs_in = '0;

    // reset held two cycles with both requests asserted
    step(1'b0);
    step(1'b0);
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_rf_rd", bus.rf_rd, 0);
    check("rst_rf_wd", bus.rf_wd, 0);
    idle(1);
    check("rst_alu_ready", bus.alu_ready, 1);
    check("rst_mem_ready", bus.mem_ready, 1);

    // single ALU write
    in_av = 1'b1; in_ard = 5'd5; in_awd = 32'hAAAA_BBBB; in_mv = 1'b0;
    step(1'b1);
    check("single_acc", acc_a, 1);
    in_av = 1'b0;
    step(1'b1);
    check("single_we",  bus.rf_we, 1);
    check("single_rd",  bus.rf_rd, 5);
    check("single_wd",  bus.rf_wd, 32'hAAAA_BBBB);
    check("single_src", bus.rf_src, SRC_ALU);
    step(1'b1);
    check("single_once", bus.rf_we, 0);

    // write to x0 is swallowed
    in_mv = 1'b1; in_mrd = '0; in_mwd = 32'hFFFF_FFFF;
    step(1'b1);
    check("x0_acc", acc_m, 1);
    check("x0_ready", bus.mem_ready, 1);
    in_mv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      check("x0_no_we", bus.rf_we, 0);
    end

    // contention: MEM,MEM,MEM,ALU with no idle cycles
    ai = 0; mi = 0; nw = 0;
    for (int c = 0; c < 100 && nw < 12; c++) begin
      in_av = (ai < 8);  in_ard = AW'(ai + 1); in_awd = 32'hA000_0000 + ai;
      in_mv = (mi < 12); in_mrd = AW'(mi + 9); in_mwd = 32'hB000_0000 + mi;
      step(1'b1);
      if (acc_a) ai++;
      if (acc_m) mi++;
      if (bus.rf_we) begin
        check("cont_src", bus.rf_src, (nw % 4 == 3) ? SRC_ALU : SRC_MEM);
        nw++;
      end else if (nw > 0) begin
        check("cont_gap", bus.rf_we, 1);
      end
    end
    check("cont_done", nw >= 12, 1);
    idle(6);

    // back-pressure: ALU rd=7 held against a continuous MEM stream
    got = 0; ng = 0;
    in_av = 1'b1; in_ard = 5'd7; in_awd = 32'hC0DE_0007;
    for (int k = 0; k < 20 && !got; k++) begin
      in_mv = 1'b1; in_mrd = AW'(10 + k % 5); in_mwd = $urandom;
      step(1'b1);
      if (acc_a) in_av = 1'b0;
      if (bus.rf_we) begin
        ng++;
        if (bus.rf_src == SRC_ALU) begin
          got = 1;
          check("bp_rd", bus.rf_rd, 7);
        end
      end
    end
    check("bp_written", got, 1);
    check("bp_bound", ng <= SM + 1, 1);
    idle(4);

    // reset with both buffers full
    in_av = 1'b1; in_ard = 5'd7; in_awd = 32'h7777_7777;
    in_mv = 1'b1; in_mrd = 5'd12; in_mwd = 32'hCCCC_CCCC;
    chk_rs_in = 5'd7;
    step(1'b1);
`ifdef REGFILE_WB_PENDCHK_EN
    check("pend_before", bus.chk_pend, 1);
`endif
    in_av = 1'b0; in_mv = 1'b0;
    step(1'b0);
    check("midrst_we", bus.rf_we, 0);
`ifdef REGFILE_WB_PENDCHK_EN
    check("pend_after", bus.chk_pend, 0);
`endif
    step(1'b1);
    check("midrst_discard", bus.rf_we, 0);
    in_av = 1'b1; in_ard = 5'd3; in_awd = 32'h0BAD_F00D;
    step(1'b1);
    in_av = 1'b0;
    step(1'b1);
    check("post_rst_we", bus.rf_we, 1);
    check("post_rst_rd", bus.rf_rd, 3);

    // randomized traffic, requests held until accepted, occasional resets
    acc_a = 1; acc_m = 1; in_av = 0; in_mv = 0;
    for (int c = 0; c < 400; c++) begin
      if (!in_av || acc_a) begin
        in_av = ($urandom_range(0, 3) != 0);
        in_ard = AW'($urandom_range(0, 7));
        in_awd = $urandom;
      end
      if (!in_mv || acc_m) begin
        in_mv = ($urandom_range(0, 3) != 0);
        in_mrd = AW'($urandom_range(0, 7));
        in_mwd = $urandom;
      end
      chk_rs_in = AW'($urandom_range(0, 7));
      step($urandom_range(0, 49) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
